// File: rtl/cdc_register_reader_pkg.sv
// Shared constants and elaboration helpers for the CDC register reader.
package cdc_register_reader_pkg;

   localparam int unsigned default_data_width       = 32;
   localparam int unsigned default_depth            = 4;
   localparam int unsigned default_drop_count_width = 8;

   // Buffer depth must be a power of two and at least two entries.
   function automatic bit valid_depth(input int unsigned d);
      return (d >= 2) && ((d & (d - 1)) == 0);
   endfunction

endpackage

// File: rtl/cdc_reader_mem.sv
// Register-array storage for the CDC reader buffer: one write port, async read.
module cdc_reader_mem #(
   parameter int unsigned data_width = 32,
   parameter int unsigned depth      = 4
) (
   input  logic                         clk,
   input  logic                         wr_en,
   input  logic [$clog2(depth)-1:0]     wr_addr,
   input  logic [data_width-1:0]        wr_data,
   input  logic [$clog2(depth)-1:0]     rd_addr,
   output logic [data_width-1:0]        rd_data
);

   logic [data_width-1:0] mem [depth];

   // Storage is intentionally not reset; validity is tracked by the controller.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cdc_register_reader.sv
// Absorbs un-throttled CDC register read strobes into a small FWFT buffer and
// presents them as a valid/ready stream; overflowing words are dropped and counted.
module cdc_register_reader
   import cdc_register_reader_pkg::*;
#(
   parameter int unsigned data_width       = default_data_width,
   parameter int unsigned depth            = default_depth,
   parameter int unsigned drop_count_width = default_drop_count_width
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [data_width-1:0]         in_data,
   input  logic                          in_rd,
   output logic [data_width-1:0]         out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(depth):0]        level,
   output logic                          overflow,
   input  logic                          clear_overflow,
   output logic [drop_count_width-1:0]   drop_count
);

   localparam int unsigned ptr_w = $clog2(depth);
   localparam int unsigned lvl_w = ptr_w + 1;

   generate
      if (!valid_depth(depth)) begin : g_bad_depth
         $error("cdc_register_reader: depth must be a power of two and >= 2");
      end
   endgenerate

   logic [ptr_w-1:0] wr_ptr;
   logic [ptr_w-1:0] rd_ptr;
   logic [lvl_w-1:0] level_next;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;

   assign full = (level == lvl_w'(depth));
   assign pop  = out_valid && out_ready;
   // A full buffer still accepts a word when the head leaves in the same cycle.
   assign push = in_rd && (!full || pop);
   assign drop = in_rd && !push;

   always_comb begin
      level_next = level;
      if (push && !pop) begin
         level_next = level + lvl_w'(1);
      end else if (pop && !push) begin
         level_next = level - lvl_w'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         out_valid  <= 1'b0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ptr_w'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ptr_w'(1);
         end
         level     <= level_next;
         out_valid <= (level_next != '0);

         // A drop coinciding with a clear wins: the new drop is the first counted.
         if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
               drop_count <= drop_count_width'(1);
            end else if (drop_count != '1) begin
               drop_count <= drop_count + drop_count_width'(1);
            end
         end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
         end
      end
   end

   cdc_reader_mem #(
      .data_width (data_width),
      .depth      (depth)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push && !reset),
      .wr_addr (wr_ptr),
      .wr_data (in_data),
      .rd_addr (rd_ptr),
      .rd_data (out_data)
   );

endmodule

// File: tb/tb_cdc_register_reader.sv
// Randomized and directed bench for cdc_register_reader against a queue-based model.
module tb_cdc_register_reader;

   localparam int unsigned dw    = 32;
   localparam int unsigned dep   = 4;
   localparam int unsigned dcw   = 2;
   localparam int unsigned dcmax = (1 << dcw) - 1;

   logic            clk = 1'b0;
   logic            reset;
   logic [dw-1:0]   in_data;
   logic            in_rd;
   logic [dw-1:0]   out_data;
   logic            out_valid;
   logic            out_ready;
   logic [2:0]      level;
   logic            overflow;
   logic            clear_overflow;
   logic [dcw-1:0]  drop_count;

   int checks = 0;
   int errors = 0;

   logic [dw-1:0] q[$];
   bit            m_overflow;
   int            m_drops;

   always #5 clk = ~clk;

   cdc_register_reader #(
      .data_width       (dw),
      .depth            (dep),
      .drop_count_width (dcw)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in_data        (in_data),
      .in_rd          (in_rd),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .level          (level),
      .overflow       (overflow),
      .clear_overflow (clear_overflow),
      .drop_count     (drop_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      int exp_dc;
      exp_dc = (m_drops > int'(dcmax)) ? int'(dcmax) : m_drops;
      check("level", 32'(level), 32'(q.size()));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("overflow", 32'(overflow), 32'(m_overflow));
      check("drop_count", 32'(drop_count), 32'(exp_dc));
      if (q.size() != 0) check("out_data", out_data, q[0]);
   endtask

   // One clock: drive inputs, advance the model with the queue semantics, compare.
   task automatic step(input logic rd, input logic [dw-1:0] d, input logic rdy,
                       input logic clr, input logic rst);
      bit m_pop, m_push;
      in_rd = rd; in_data = d; out_ready = rdy; clear_overflow = clr; reset = rst;
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         m_overflow = 0;
         m_drops    = 0;
      end else begin
         m_pop  = (q.size() != 0) && rdy;
         m_push = rd && ((q.size() < dep) || m_pop);
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back(d);
         if (clr) begin
            m_overflow = 0;
            m_drops    = 0;
         end
         if (rd && !m_push) begin
            m_overflow = 1;
            m_drops++;
         end
      end
      in_rd = 1'b0; clear_overflow = 1'b0; reset = 1'b0; out_ready = 1'b0;
      compare_all();
   endtask

   initial begin
      in_rd = 0; in_data = '0; out_ready = 0; clear_overflow = 0; reset = 1;
      step(0, '0, 0, 0, 1);
      step(0, '0, 0, 0, 1);
      check("rst_level", 32'(level), 0);
      check("rst_out_valid", 32'(out_valid), 0);

      // Three strobes held, then drained in order.
      step(1, 32'hA1, 0, 0, 0);
      check("t1_first_visible", 32'(out_valid), 1);
      step(1, 32'hA2, 0, 0, 0);
      step(1, 32'hA3, 0, 0, 0);
      check("t1_level3", 32'(level), 3);
      check("t1_head", out_data, 32'hA1);
      step(0, '0, 1, 0, 0);
      check("t1_head2", out_data, 32'hA2);
      step(0, '0, 1, 0, 0);
      check("t1_head3", out_data, 32'hA3);
      step(0, '0, 1, 0, 0);
      check("t1_empty", 32'(level), 0);

      // Full buffer drops the next strobe.
      for (int i = 0; i < 4; i++) step(1, 32'hB0 + 32'(i), 0, 0, 0);
      step(1, 32'hFF, 0, 0, 0);
      check("t2_level", 32'(level), 4);
      check("t2_overflow", 32'(overflow), 1);
      check("t2_drop_count", 32'(drop_count), 1);
      check("t2_head_kept", out_data, 32'hB0);

      // Saturation and clear-versus-drop priority.
      step(0, '0, 0, 1, 0);
      check("t4_cleared", 32'(drop_count), 0);
      for (int i = 0; i < 5; i++) step(1, 32'hC0 + 32'(i), 0, 0, 0);
      check("t4_saturated", 32'(drop_count), 3);
      step(1, 32'hCC, 0, 1, 0);
      check("t4_clr_drop_ovf", 32'(overflow), 1);
      check("t4_clr_drop_cnt", 32'(drop_count), 1);

      // Full buffer with simultaneous push and pop.
      step(1, 32'h55, 1, 0, 0);
      check("t3_level", 32'(level), 4);
      check("t3_no_drop", 32'(drop_count), 1);
      for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);
      check("t3_tail", out_data, 32'h55);
      step(0, '0, 1, 0, 0);
      step(0, '0, 0, 1, 0);

      // Pointer wrap with random back-pressure.
      for (int i = 0; i < 10; i++) begin
         while (q.size() >= dep) step(0, '0, 1'($urandom_range(0, 1)), 0, 0);
         step(1, $urandom, 1'($urandom_range(0, 1)), 0, 0);
      end
      while (q.size() != 0) step(0, '0, 1'($urandom_range(0, 1)), 0, 0);

      // Reset mid-operation with a strobe present.
      step(1, 32'hD1, 0, 0, 0);
      step(1, 32'hD2, 0, 0, 0);
      step(1, 32'hEE, 0, 0, 1);
      check("t6_level", 32'(level), 0);
      check("t6_valid", 32'(out_valid), 0);
      check("t6_overflow", 32'(overflow), 0);
      check("t6_drop_count", 32'(drop_count), 0);
      step(0, '0, 1, 0, 0);
      check("t6_not_stored", 32'(out_valid), 0);

      // Long random run.
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 99) < 60), $urandom,
              1'($urandom_range(0, 99) < 45),
              1'($urandom_range(0, 99) < 5),
              1'($urandom_range(0, 199) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
